// File: rtl/ring_rr_arbiter_if.sv
// Bundles the requester-side and status signals of the ring round-robin arbiter.
// The master modport drives requests; the slave modport is the arbiter itself.
interface ring_rr_arbiter_if #(
  parameter int unsigned JW = 4
);
  logic [3:0]    req;
  logic          en;
  logic [3:0]    gnt;
  logic [1:0]    gnt_id;
  logic          busy;
  logic [3:0]    token;
  logic [JW-1:0] jcnt;
  logic          q_exp;

  modport master (
    output req,
    output en,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  token,
    input  jcnt,
    input  q_exp
  );

  modport slave (
    input  req,
    input  en,
    output gnt,
    output gnt_id,
    output busy,
    output token,
    output jcnt,
    output q_exp
  );
endinterface

// File: rtl/ring_rr_arbiter.sv
// Four-requester round-robin arbiter with a one-hot token ring and a Johnson-counter
// grant quantum of 2*JW cycles; grants hand off without an idle bubble.
module ring_rr_arbiter #(
  parameter int unsigned JW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  ring_rr_arbiter_if.slave   bus
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]      state_q,  state_d;
  logic [NREQ-1:0] gnt_q,    gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [NREQ-1:0] token_q,  token_d;
  logic [JW-1:0]   jcnt_q,   jcnt_d;
  logic            q_exp_q,  q_exp_d;

  logic            holder_req;
  logic            jcnt_last;
  logic            release_c;
  logic            expire_c;
  logic [NREQ-1:0] tok_rot;
  logic [IDW-1:0]  win_idle;
  logic [IDW-1:0]  win_hand;

  // Circular scan of r starting at the token position, ascending with wrap.
  function automatic logic [IDW-1:0] pick(input logic [NREQ-1:0] r,
                                          input logic [NREQ-1:0] tok);
    logic [IDW-1:0] start;
    logic [IDW-1:0] idx;
    logic           found;
    start = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (tok[i]) start = IDW'(i);
    end
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = start + IDW'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign holder_req = bus.req[gnt_id_q];
  assign jcnt_last  = (jcnt_q == JW'(1));
  assign release_c  = (state_q == ST_GRANT) && !holder_req;
  assign expire_c   = (state_q == ST_GRANT) && holder_req && jcnt_last;
  // Ended holder becomes lowest priority: token moves one position above it.
  assign tok_rot    = {gnt_q[NREQ-2:0], gnt_q[NREQ-1]};
  assign win_idle   = pick(bus.req, token_q);
  assign win_hand   = pick(bus.req, tok_rot);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    token_d  = token_q;
    jcnt_d   = jcnt_q;
    q_exp_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.en && (|bus.req)) begin
          state_d  = ST_GRANT;
          gnt_id_d = win_idle;
          gnt_d    = NREQ'(1) << win_idle;
          jcnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (release_c || expire_c) begin
          token_d = tok_rot;
          q_exp_d = expire_c;
          if (bus.en && (|bus.req)) begin
            gnt_id_d = win_hand;
            gnt_d    = NREQ'(1) << win_hand;
            jcnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else begin
          jcnt_d = {~jcnt_q[0], jcnt_q[JW-1:1]};
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      token_q  <= NREQ'(1);
      jcnt_q   <= '0;
      q_exp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      token_q  <= token_d;
      jcnt_q   <= jcnt_d;
      q_exp_q  <= q_exp_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = (state_q == ST_GRANT);
  assign bus.token  = token_q;
  assign bus.jcnt   = jcnt_q;
  assign bus.q_exp  = q_exp_q;

endmodule
